// File: rtl/pipe_reg_elastic.sv
// Elastic pipeline stage register: valid/ready handshake with a 2-entry skid
// buffer, registered InReady and a synchronous flush that drops in-flight data.
module pipe_reg_elastic #(
   parameter int unsigned      WIDTH          = 32,
   parameter logic [WIDTH-1:0] RESET_VALUE    = '0,
   parameter bit               CLEAR_ON_FLUSH = 1'b1
) (
   input  logic             Clk,
   input  logic             Reset_n,
   input  logic             Flush,
   input  logic [WIDTH-1:0] In,
   input  logic             InValid,
   output logic             InReady,
   output logic [WIDTH-1:0] Out,
   output logic             OutValid,
   input  logic             OutReady,
   output logic [1:0]       Count
);

   // Encoding doubles as the occupancy count.
   typedef enum logic [1:0] {
      StEmpty = 2'd0,
      StBusy  = 2'd1,
      StFull  = 2'd2
   } state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] main_q, main_d;
   logic [WIDTH-1:0] skid_q, skid_d;
   logic             in_ready_q, in_ready_d;
   logic             in_fire, out_fire;

   assign in_fire  = InValid & in_ready_q;
   assign out_fire = (state_q != StEmpty) & OutReady;

   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      if (Flush) begin
         state_d = StEmpty;
         if (CLEAR_ON_FLUSH) begin
            main_d = RESET_VALUE;
            skid_d = RESET_VALUE;
         end
      end else begin
         unique case (state_q)
            StEmpty: begin
               if (in_fire) begin
                  main_d  = In;
                  state_d = StBusy;
               end
            end
            StBusy: begin
               if (in_fire && out_fire) begin
                  main_d = In;
               end else if (in_fire) begin
                  skid_d  = In;
                  state_d = StFull;
               end else if (out_fire) begin
                  state_d = StEmpty;
               end
            end
            StFull: begin
               // InReady is low here, so only the drain path is possible.
               if (out_fire) begin
                  main_d  = skid_q;
                  state_d = StBusy;
               end
            end
            default: state_d = StEmpty;
         endcase
      end
      in_ready_d = (state_d != StFull);
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q    <= StEmpty;
         main_q     <= RESET_VALUE;
         skid_q     <= RESET_VALUE;
         in_ready_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         main_q     <= main_d;
         skid_q     <= skid_d;
         in_ready_q <= in_ready_d;
      end
   end

   assign InReady  = in_ready_q;
   assign Out      = main_q;
   assign OutValid = (state_q != StEmpty);
   assign Count    = state_q;

endmodule

// File: tb/tb_pipe_reg_elastic.sv
// Self-checking bench for pipe_reg_elastic: directed vector table, hand-written
// corner sequences and random traffic checked against a queue-based model.
module tb_pipe_reg_elastic;

   logic        Clk = 1'b0;
   logic        Reset_n;
   logic        Flush;
   logic [31:0] In;
   logic        InValid;
   logic        InReady;
   logic [31:0] Out;
   logic        OutValid;
   logic        OutReady;
   logic [1:0]  Count;

   logic        v_rst_n;
   logic        v_flush;
   logic [7:0]  v_in;
   logic        v_in_valid;
   logic        v_in_ready;
   logic [7:0]  v_out;
   logic        v_out_valid;
   logic        v_out_ready;
   logic [1:0]  v_count;

   int errors = 0;
   int checks = 0;

   always #5 Clk = ~Clk;

   pipe_reg_elastic #(
      .WIDTH(32), .RESET_VALUE(32'h0), .CLEAR_ON_FLUSH(1'b1)
   ) u_dut (
      .Clk(Clk), .Reset_n(Reset_n), .Flush(Flush), .In(In), .InValid(InValid),
      .InReady(InReady), .Out(Out), .OutValid(OutValid), .OutReady(OutReady),
      .Count(Count)
   );

   pipe_reg_elastic #(
      .WIDTH(8), .RESET_VALUE(8'hFF), .CLEAR_ON_FLUSH(1'b0)
   ) u_dut_v (
      .Clk(Clk), .Reset_n(v_rst_n), .Flush(v_flush), .In(v_in), .InValid(v_in_valid),
      .InReady(v_in_ready), .Out(v_out), .OutValid(v_out_valid), .OutReady(v_out_ready),
      .Count(v_count)
   );

   // Reference model: FIFO of accepted words, capacity 2.
   logic [31:0] mq[$];
   logic [31:0] m_last = 32'h0;
   bit          m_ready = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_check();
      logic [31:0] m_out;
      m_out = (mq.size() > 0) ? mq[0] : m_last;
      chk("model Out", Out, m_out);
      chk("model OutValid", 32'(OutValid), 32'(mq.size() > 0));
      chk("model Count", 32'(Count), 32'(mq.size()));
      chk("model InReady", 32'(InReady), 32'(m_ready));
   endtask

   task automatic model_reset();
      mq.delete();
      m_last  = 32'h0;
      m_ready = 1'b0;
   endtask

   // Drive one cycle of inputs, advance the model, then sample 1 after the edge.
   task automatic step(input logic [31:0] d, input bit v, input bit r, input bit f);
      bit in_fire, out_fire;
      In = d; InValid = v; OutReady = r; Flush = f;
      in_fire  = v && m_ready;
      out_fire = (mq.size() > 0) && r;
      if (Reset_n) begin
         if (f) begin
            mq.delete();
            m_last = 32'h0;
         end else begin
            if (out_fire) void'(mq.pop_front());
            if (in_fire) mq.push_back(d);
         end
         m_ready = (mq.size() < 2);
         if (mq.size() > 0) m_last = mq[0];
      end
      @(posedge Clk);
      #1;
      model_check();
   endtask

   typedef struct {
      logic [31:0] din;
      bit          vld;
      bit          ordy;
      bit          fl;
      logic [31:0] e_out;
      bit          e_valid;
      logic [1:0]  e_count;
      bit          e_ready;
   } vec_t;

   vec_t vecs[$];

   initial begin
      bit          hold_v;
      logic [31:0] hold_d;

      Reset_n = 1'b0; Flush = 1'b0; In = '0; InValid = 1'b0; OutReady = 1'b0;
      v_rst_n = 1'b0; v_flush = 1'b0; v_in = '0; v_in_valid = 1'b0; v_out_ready = 1'b0;
      model_reset();

      // Reset release
      repeat (3) begin
         @(negedge Clk);
         chk("reset Out", Out, 32'h0);
         chk("reset OutValid", 32'(OutValid), 32'h0);
         chk("reset InReady", 32'(InReady), 32'h0);
         chk("reset Count", 32'(Count), 32'h0);
      end
      Reset_n = 1'b1;
      step(32'h0, 1'b0, 1'b0, 1'b0);
      chk("release InReady", 32'(InReady), 32'h1);

      // Streaming
      for (int i = 1; i <= 8; i++)
         vecs.push_back('{32'(i), 1, 1, 0, 32'(i), 1, 2'd1, 1});
      vecs.push_back('{32'h0, 0, 1, 0, 32'h8, 0, 2'd0, 1});
      // Stall fill, refused third word, drain in order
      vecs.push_back('{32'hAAAA0001, 1, 0, 0, 32'hAAAA0001, 1, 2'd1, 1});
      vecs.push_back('{32'hAAAA0002, 1, 0, 0, 32'hAAAA0001, 1, 2'd2, 0});
      vecs.push_back('{32'hAAAA0003, 1, 0, 0, 32'hAAAA0001, 1, 2'd2, 0});
      vecs.push_back('{32'hAAAA0003, 1, 1, 0, 32'hAAAA0002, 1, 2'd1, 1});
      vecs.push_back('{32'hAAAA0003, 1, 1, 0, 32'hAAAA0003, 1, 2'd1, 1});
      vecs.push_back('{32'h0, 0, 1, 0, 32'hAAAA0003, 0, 2'd0, 1});
      // Flush in FULL with a simultaneous input
      vecs.push_back('{32'h11, 1, 0, 0, 32'h11, 1, 2'd1, 1});
      vecs.push_back('{32'h22, 1, 0, 0, 32'h11, 1, 2'd2, 0});
      vecs.push_back('{32'hDEADBEEF, 1, 0, 1, 32'h0, 0, 2'd0, 1});
      vecs.push_back('{32'h0, 0, 1, 0, 32'h0, 0, 2'd0, 1});

      foreach (vecs[i]) begin
         step(vecs[i].din, vecs[i].vld, vecs[i].ordy, vecs[i].fl);
         chk($sformatf("vec%0d Out", i), Out, vecs[i].e_out);
         chk($sformatf("vec%0d OutValid", i), 32'(OutValid), 32'(vecs[i].e_valid));
         chk($sformatf("vec%0d Count", i), 32'(Count), 32'(vecs[i].e_count));
         chk($sformatf("vec%0d InReady", i), 32'(InReady), 32'(vecs[i].e_ready));
      end

      // Asynchronous reset mid-transfer
      step(32'h12345678, 1'b1, 1'b0, 1'b0);
      step(32'h0, 1'b0, 1'b0, 1'b0);
      chk("busy Out", Out, 32'h12345678);
      #2;
      Reset_n = 1'b0;
      model_reset();
      #1;
      chk("async OutValid", 32'(OutValid), 32'h0);
      chk("async Out", Out, 32'h0);
      chk("async Count", 32'(Count), 32'h0);
      chk("async InReady", 32'(InReady), 32'h0);
      step(32'h0, 1'b0, 1'b0, 1'b0);
      @(negedge Clk);
      Reset_n = 1'b1;
      step(32'h0, 1'b0, 1'b0, 1'b0);
      chk("rerelease InReady", 32'(InReady), 32'h1);

      // Random traffic; upstream holds an offered word until it is taken
      hold_v = 1'b0;
      hold_d = '0;
      for (int c = 0; c < 400; c++) begin
         bit f, r, accepted;
         f = ($urandom_range(0, 19) == 0);
         r = ($urandom_range(0, 9) < 6);
         if (!hold_v) begin
            hold_v = ($urandom_range(0, 9) < 7);
            hold_d = $urandom;
         end
         accepted = hold_v && m_ready;
         step(hold_d, hold_v, r, f);
         if (accepted || f) hold_v = 1'b0;
      end

      // Parameter variant: WIDTH=8, RESET_VALUE=0xFF, CLEAR_ON_FLUSH=0
      @(negedge Clk);
      chk("var reset Out", 32'(v_out), 32'hFF);
      chk("var reset OutValid", 32'(v_out_valid), 32'h0);
      v_rst_n = 1'b1;
      @(posedge Clk); #1;
      chk("var release InReady", 32'(v_in_ready), 32'h1);
      chk("var idle Out", 32'(v_out), 32'hFF);
      v_in = 8'h3C; v_in_valid = 1'b1;
      @(posedge Clk); #1;
      v_in_valid = 1'b0;
      chk("var push Out", 32'(v_out), 32'h3C);
      chk("var push OutValid", 32'(v_out_valid), 32'h1);
      v_flush = 1'b1;
      @(posedge Clk); #1;
      v_flush = 1'b0;
      chk("var flush OutValid", 32'(v_out_valid), 32'h0);
      chk("var flush Out", 32'(v_out), 32'h3C);
      chk("var flush Count", 32'(v_count), 32'h0);
      chk("var flush InReady", 32'(v_in_ready), 32'h1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/pipe_reg_elastic.md
Name: pipe_reg_elastic

Overview:
- Parametrised successor to the plain 32-bit pipeline register: a WIDTH-bit pipeline stage register with a valid/ready handshake, a 2-entry skid buffer and a synchronous flush.
- Sits between MIPS pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Downstream stalls are absorbed without a combinational ready path from output to input.
- Flush drops in-flight instructions on branch/jump or exception.

Parameters:
- WIDTH, 32, data width in bits.
- RESET_VALUE, 0 (WIDTH bits), value driven on Out after reset and after a clearing flush.
- CLEAR_ON_FLUSH, 1, 1 = main and skid data registers load RESET_VALUE on flush; 0 = data registers hold and only the valid state clears.

Ports:
- Clk  input  1  rising-edge clock.
- Reset_n  input  1  asynchronous, active-low reset.
- Flush  input  1  synchronous flush, highest priority after reset.
- In  input  WIDTH  upstream data.
- InValid  input  1  upstream data valid.
- InReady  output  1  stage can accept; registered output.
- Out  output  WIDTH  stage data; driven directly from the main register.
- OutValid  output  1  Out holds a valid entry.
- OutReady  input  1  downstream accepts Out this cycle.
- Count  output  2  occupancy, 0..2.

Behaviour:
- Reset (Reset_n=0, asynchronous):
  - State EMPTY; OutValid=0, InReady=0, Count=0.
  - Out=RESET_VALUE; skid register=RESET_VALUE.
  - InReady rises on the first Clk edge after Reset_n deasserts.
- Fire definitions: in_fire = InValid & InReady; out_fire = OutValid & OutReady.
- States (Count = state encoding):
  - EMPTY (0): OutValid=0.
  - BUSY (1): main register valid.
  - FULL (2): main and skid registers both valid.
- Transitions (Flush=0):
  - EMPTY: in_fire -> main<=In, BUSY. Otherwise stay.
  - BUSY, in_fire & out_fire -> main<=In, stay BUSY.
  - BUSY, in_fire only -> skid<=In, FULL.
  - BUSY, out_fire only -> EMPTY.
  - BUSY, neither -> hold.
  - FULL: InReady=0, so no in_fire is possible. out_fire -> main<=skid, BUSY. Otherwise hold.
- InReady is registered and equals (next_state != FULL), except 0 while in reset.
- No combinational path from OutReady to InReady.
- Latency: data accepted at edge N appears on Out with OutValid=1 after edge N when the stage was EMPTY, or BUSY with out_fire.
- Throughput: 1 transfer/cycle sustained while OutReady=1.
- Stability: while OutValid=1 and OutReady=0, Out and OutValid must not change, unless Flush or reset.
- Ordering: strict FIFO order. The skid entry is never presented before the main entry.
- Flush=1 at a Clk edge:
  - Next state EMPTY, OutValid=0, Count=0, InReady=1.
  - Any in_fire that cycle is discarded.
  - out_fire in the same cycle is still counted as consumed by downstream; the stage does not replay it.
  - CLEAR_ON_FLUSH=1: main and skid registers load RESET_VALUE. CLEAR_ON_FLUSH=0: they hold.
- Reset mid-operation: immediate (asynchronous) return to reset values regardless of state, Flush or handshakes.
- Count is always consistent with state and never exceeds 2. Overflow is impossible because InReady=0 in FULL.
- InValid=1 with InReady=0 does not change state. Upstream must hold In/InValid until accepted.

Test Plan:
- Reset release:
  - Stimulus: hold Reset_n=0 for 3 cycles, then release.
  - Required: during reset Out=0, OutValid=0, InReady=0, Count=0; InReady=1 after the first edge following release.
- Streaming:
  - Stimulus: OutReady=1, present In=0x00000001..0x00000008 with InValid=1 on consecutive cycles.
  - Required: Out shows 1..8 in order, one per cycle, each one cycle after its input; Count stays 1; InReady stays 1.
- Stall fill:
  - Stimulus: OutReady=0, push 0xAAAA0001 then 0xAAAA0002.
  - Required: Count=2, InReady=0, Out holds 0xAAAA0001.
  - Continuation: a third word 0xAAAA0003 presented with InValid=1 is not accepted.
  - Continuation: then OutReady=1; Out sequence is 0xAAAA0001, 0xAAAA0002, 0xAAAA0003 with no loss or duplication.
- Flush in FULL with simultaneous input (CLEAR_ON_FLUSH=1):
  - Stimulus: FULL state, pulse Flush with InValid=1, In=0xDEADBEEF.
  - Required next cycle: OutValid=0, Count=0, Out=RESET_VALUE, InReady=1; 0xDEADBEEF never appears on Out.
- Asynchronous reset mid-transfer:
  - Stimulus: in BUSY with Out=0x12345678, drop Reset_n between clock edges.
  - Required: OutValid=0 and Out=0 immediately, without waiting for a Clk edge.
- Parameter variant, WIDTH=8, RESET_VALUE=0xFF, CLEAR_ON_FLUSH=0:
  - Stimulus: after reset, push 0x3C, then Flush.
  - Required: after reset Out=0xFF; after the flush OutValid=0 and Out remains 0x3C.
